// File: rtl/nand_target.sv
// ============================================================================
// Module   : nand_target
// Brief    : NAND flash device emulator; responder end of an ONFI-style bus
//            with Reset, Read ID, Read Status and Page Read commands.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module nand_target #(
  parameter logic [31:0] ID_WORD     = 32'hECD35195,
  parameter logic [15:0] BUSY_CYCLES = 16'd250,
  parameter int          ADDR_CYCLES = 5,
  parameter int          PAGE_BYTES  = 2112
) (
  input  logic        clk10,
  input  logic        rst,
  input  logic        nd_ce_n,
  input  logic        nd_cle,
  input  logic        nd_ale,
  input  logic        nd_we_n,
  input  logic        nd_re_n,
  input  logic        nd_wp_n,
  input  logic [7:0]  nd_io_in,
  output logic [7:0]  nd_io_out,
  output logic        nd_io_oe,
  output logic        nd_r_b_n,
  output logic        fetch_req,
  output logic [23:0] fetch_row,
  input  logic        fetch_ack,
  output logic [11:0] data_addr,
  input  logic [7:0]  data_in
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ID_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_ADDR = 3'd2;
  localparam logic [2:0] ST_RD_CONF = 3'd3;
  localparam logic [2:0] ST_BUSY    = 3'd4;

  localparam logic [1:0] C_MODE_NONE   = 2'd0;
  localparam logic [1:0] C_MODE_ID     = 2'd1;
  localparam logic [1:0] C_MODE_STATUS = 2'd2;
  localparam logic [1:0] C_MODE_DATA   = 2'd3;

  localparam logic [7:0] C_CMD_RESET     = 8'hFF;
  localparam logic [7:0] C_CMD_READ_ID   = 8'h90;
  localparam logic [7:0] C_CMD_STATUS    = 8'h70;
  localparam logic [7:0] C_CMD_READ      = 8'h00;
  localparam logic [7:0] C_CMD_READ_CONF = 8'h30;

  localparam int               C_ACW       = $clog2(ADDR_CYCLES + 1);
  localparam logic [C_ACW-1:0] C_ADDR_LAST = C_ACW'(ADDR_CYCLES - 1);
  localparam logic [15:0]      C_COL_LAST  = 16'(PAGE_BYTES - 1);

  // Bundle order: {ce_n, cle, ale, we_n, re_n, wp_n, io[7:0]}; strobes idle high
  localparam logic [13:0] C_SYNC_IDLE = 14'b1_0_0_1_1_1_0000_0000;

  logic [13:0]      r_sync_m;
  logic [13:0]      r_sync_s;
  logic             r_we_n_d;
  logic             r_re_n_d;
  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [1:0]       r_mode;
  logic [1:0]       r_mode_sav;
  logic [1:0]       r_id_idx;
  logic [C_ACW-1:0] r_acnt;
  logic [15:0]      r_col_lat;
  logic [15:0]      r_column;
  logic [15:0]      w_column_nxt;
  logic [23:0]      r_row;
  logic [23:0]      r_fetch_row;
  logic             r_fetch_req;
  logic             r_rd_pend;
  logic [15:0]      r_counter;
  logic [7:0]       r_io_out;
  logic             r_io_oe;

  logic       w_ce_n_s;
  logic       w_cle_s;
  logic       w_ale_s;
  logic       w_we_n_s;
  logic       w_re_n_s;
  logic       w_wp_n_s;
  logic [7:0] w_io_s;
  logic       w_we_ev;
  logic       w_re_ev;
  logic       w_cmd_ev;
  logic       w_addr_ev;
  logic       w_reset_cmd;
  logic       w_busy_exit;
  logic       w_rdy;
  logic [7:0] w_status;
  logic [7:0] w_id_byte;
  logic [7:0] w_io_nxt;
  logic       w_oe_nxt;

  always_ff @(posedge clk10) begin
    if (rst) begin
      r_sync_m <= C_SYNC_IDLE;
      r_sync_s <= C_SYNC_IDLE;
      r_we_n_d <= 1'b1;
      r_re_n_d <= 1'b1;
    end else begin
      r_sync_m <= {nd_ce_n, nd_cle, nd_ale, nd_we_n, nd_re_n, nd_wp_n, nd_io_in};
      r_sync_s <= r_sync_m;
      r_we_n_d <= w_we_n_s;
      r_re_n_d <= w_re_n_s;
    end
  end

  assign w_ce_n_s = r_sync_s[13];
  assign w_cle_s  = r_sync_s[12];
  assign w_ale_s  = r_sync_s[11];
  assign w_we_n_s = r_sync_s[10];
  assign w_re_n_s = r_sync_s[9];
  assign w_wp_n_s = r_sync_s[8];
  assign w_io_s   = r_sync_s[7:0];

  // Strobes act on their rising edge, and only while the chip is selected
  assign w_we_ev     = w_we_n_s & ~r_we_n_d & ~w_ce_n_s;
  assign w_re_ev     = w_re_n_s & ~r_re_n_d & ~w_ce_n_s;
  assign w_cmd_ev    = w_we_ev & w_cle_s & ~w_ale_s;
  assign w_addr_ev   = w_we_ev & w_ale_s & ~w_cle_s;
  assign w_reset_cmd = w_cmd_ev & (w_io_s == C_CMD_RESET);
  assign w_busy_exit = (r_state == ST_BUSY) & (r_counter == 16'd0) & ~r_fetch_req & ~w_reset_cmd;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk10) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    if (w_busy_exit) begin
      w_state_nxt = ST_IDLE;
    end
    if (w_cmd_ev) begin
      case (w_io_s)
        C_CMD_RESET:  w_state_nxt = ST_BUSY;
        C_CMD_STATUS: w_state_nxt = r_state;
        C_CMD_READ_CONF: begin
          if (r_state == ST_RD_CONF) begin
            w_state_nxt = ST_BUSY;
          end
        end
        C_CMD_READ_ID: begin
          if (r_state == ST_IDLE) begin
            w_state_nxt = ST_ID_ADDR;
          end else if (r_state != ST_BUSY) begin
            w_state_nxt = ST_IDLE;
          end
        end
        C_CMD_READ: begin
          if (r_state == ST_IDLE) begin
            if (r_mode != C_MODE_STATUS) begin
              w_state_nxt = ST_RD_ADDR;
            end
          end else if (r_state != ST_BUSY) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          if (r_state != ST_BUSY) begin
            w_state_nxt = ST_IDLE;
          end
        end
      endcase
    end else if (w_addr_ev) begin
      if (r_state == ST_ID_ADDR) begin
        w_state_nxt = ST_IDLE;
      end else if ((r_state == ST_RD_ADDR) && (r_acnt == C_ADDR_LAST)) begin
        w_state_nxt = ST_RD_CONF;
      end
    end
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk10) begin
    if (rst) begin
      r_mode      <= C_MODE_NONE;
      r_mode_sav  <= C_MODE_NONE;
      r_id_idx    <= 2'd0;
      r_acnt      <= '0;
      r_col_lat   <= 16'd0;
      r_row       <= 24'd0;
      r_fetch_row <= 24'd0;
      r_fetch_req <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_counter   <= 16'd0;
    end else begin
      // A status read issued during BUSY keeps STATUS visible; DATA is resumed by 00h
      if (w_busy_exit && r_rd_pend) begin
        if (r_mode == C_MODE_STATUS) begin
          r_mode_sav <= C_MODE_DATA;
        end else begin
          r_mode <= C_MODE_DATA;
        end
        r_rd_pend <= 1'b0;
      end
      if ((r_state == ST_BUSY) && (r_counter != 16'd0)) begin
        r_counter <= r_counter - 16'd1;
      end
      if (fetch_ack) begin
        r_fetch_req <= 1'b0;
      end
      if (w_re_ev && (r_mode == C_MODE_ID)) begin
        r_id_idx <= r_id_idx + 2'd1;
      end
      if (w_addr_ev) begin
        if (r_state == ST_ID_ADDR) begin
          r_mode   <= C_MODE_ID;
          r_id_idx <= 2'd0;
        end else if (r_state == ST_RD_ADDR) begin
          if (r_acnt == C_ACW'(0))      r_col_lat[7:0]  <= w_io_s;
          else if (r_acnt == C_ACW'(1)) r_col_lat[15:8] <= w_io_s;
          else if (r_acnt == C_ACW'(2)) r_row[7:0]      <= w_io_s;
          else if (r_acnt == C_ACW'(3)) r_row[15:8]     <= w_io_s;
          else                          r_row[23:16]    <= w_io_s;
          r_acnt <= r_acnt + 1'b1;
        end
      end
      if (w_cmd_ev) begin
        case (w_io_s)
          C_CMD_RESET: begin
            r_fetch_req <= 1'b0;
            r_mode      <= C_MODE_NONE;
            r_counter   <= BUSY_CYCLES;
            r_rd_pend   <= 1'b0;
          end
          C_CMD_STATUS: begin
            if (r_mode != C_MODE_STATUS) begin
              r_mode_sav <= r_mode;
              r_mode     <= C_MODE_STATUS;
            end
          end
          C_CMD_READ: begin
            if (r_state == ST_IDLE) begin
              if (r_mode == C_MODE_STATUS) begin
                r_mode <= r_mode_sav;
              end else begin
                r_acnt <= '0;
              end
            end
          end
          C_CMD_READ_CONF: begin
            if (r_state == ST_RD_CONF) begin
              r_fetch_row <= r_row;
              r_fetch_req <= 1'b1;
              r_counter   <= BUSY_CYCLES;
              r_rd_pend   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The RAM is addressed with the upcoming column so the byte is ready one cycle sooner
  always_comb begin
    w_column_nxt = r_column;
    if (w_busy_exit && r_rd_pend) begin
      w_column_nxt = r_col_lat;
    end else if (w_re_ev && (r_mode == C_MODE_DATA)) begin
      w_column_nxt = (r_column == C_COL_LAST) ? 16'd0 : r_column + 16'd1;
    end
    if (rst) begin
      w_column_nxt = 16'd0;
    end
  end

  always_ff @(posedge clk10) begin
    r_column <= w_column_nxt;
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    w_rdy     = (r_state != ST_BUSY);
    w_status  = {w_wp_n_s, w_rdy, w_rdy, 5'b0_0000};
    w_id_byte = ID_WORD[{~r_id_idx, 3'b000} +: 8];
    w_io_nxt  = 8'h00;
    case (r_mode)
      C_MODE_ID:     w_io_nxt = w_id_byte;
      C_MODE_STATUS: w_io_nxt = w_status;
      C_MODE_DATA:   w_io_nxt = data_in;
      default:       w_io_nxt = 8'h00;
    endcase
    w_oe_nxt = ~w_ce_n_s & ~w_re_n_s & (r_mode != C_MODE_NONE);
  end

  always_ff @(posedge clk10) begin
    if (rst) begin
      r_io_out <= 8'h00;
      r_io_oe  <= 1'b0;
    end else begin
      r_io_out <= w_io_nxt;
      r_io_oe  <= w_oe_nxt;
    end
  end

  assign nd_io_out = r_io_out;
  assign nd_io_oe  = r_io_oe;
  assign nd_r_b_n  = w_rdy;
  assign fetch_req = r_fetch_req;
  assign fetch_row = r_fetch_row;
  assign data_addr = w_column_nxt[11:0];

endmodule

`default_nettype wire

// File: doc/nand_target.md
Name: nand_target

Overview:
- Emulates a NAND flash device on the FPGA: the responder end of the ONFI-style NAND bus that the EPP-to-NAND bridge drives as host.
- Decodes CLE/ALE/WE/RE strobes and supports Reset (FFh), Read ID (90h), Read Status (70h) and Page Read (00h + address cycles + 30h).
- Drives R/B# and the output bytes; page data comes from a back-end block RAM through a fetch handshake.

Parameters:
ID_WORD, 32'hECD35195, four ID bytes returned MSB first
BUSY_CYCLES, 16'd250, minimum R/B# low time in clk10 cycles for FFh and 30h
ADDR_CYCLES, 5, address cycles for 00h (2 column + 3 row, LSB first)
PAGE_BYTES, 2112, column wrap point

Ports:
clk10 input 1 system clock
rst input 1 synchronous active-high reset
nd_ce_n input 1 chip enable, active low
nd_cle input 1 command latch enable
nd_ale input 1 address latch enable
nd_we_n input 1 write strobe, latched on rising edge
nd_re_n input 1 read strobe
nd_wp_n input 1 write protect, reported in status only
nd_io_in input 8 bus value from host
nd_io_out output 8 byte driven to host
nd_io_oe output 1 tristate enable for nd_io_out
nd_r_b_n output 1 ready/busy, 1 = ready
fetch_req output 1 page fetch request
fetch_row output 24 row address for fetch
fetch_ack input 1 one-cycle pulse, page loaded
data_addr output 12 column into page buffer
data_in input 8 page buffer byte, 1-cycle read latency

Behaviour:
- All nd_* inputs pass through a two-flop synchronizer. WE event = synchronized we_n 0->1; RE event = synchronized re_n 0->1. Both are ignored while synchronized ce_n=1.
- WE event with cle=1, ale=0: command byte = synchronized io. With ale=1, cle=0: address byte. Both high or both low: ignored.
- Modes: NONE, ID, STATUS, DATA. Command FSM: IDLE, ID_ADDR, RD_ADDR (counter 0..ADDR_CYCLES-1), RD_CONF, BUSY.
- FFh, accepted in any state: abort fetch (fetch_req=0), mode NONE, go BUSY with counter=BUSY_CYCLES.
- 90h in IDLE: go ID_ADDR. The next address byte, any value, sets mode ID, id_idx=0, state IDLE.
- 70h in any state: mode STATUS and save the previous mode; FSM state is unchanged. Status byte = {wp_n_s, rdy, rdy, 4'b0, 1'b0}.
- 00h in IDLE:
  - If mode is STATUS: restore the saved mode, column unchanged, no address phase.
  - Otherwise: go RD_ADDR. Bytes 0-1 form column[15:0]; bytes 2-4 form row[23:0], LSB first. After the last byte, go RD_CONF.
- 30h in RD_CONF: fetch_row=row, fetch_req=1, counter=BUSY_CYCLES, go BUSY. 30h in any other state is ignored.
- Any other command (including 00h/90h while BUSY or mid-address) returns the FSM to IDLE, except in BUSY where it is ignored. Unexpected address bytes are ignored.
- BUSY: the counter decrements to 0. fetch_req holds until fetch_ack, then drops. Leave BUSY to IDLE when counter=0 and fetch_req=0. A read exit sets mode DATA with column=latched column; an FFh exit leaves mode NONE.
- nd_r_b_n = 0 exactly while in BUSY (registered; low one cycle after the decoding edge).
- RE event advances the read pointer: ID mode id_idx+1 (2-bit wrap); DATA mode column+1, wrapping PAGE_BYTES-1 -> 0.
- data_addr = column[11:0]. nd_io_out is registered every cycle: ID byte[id_idx], status, data_in, or 8'h00 for NONE.
- nd_io_oe = ~ce_n_s & ~re_n_s & (mode != NONE), registered.
- Pin-to-response latency: at most 4 clk10 cycles.
- rst (any time, including mid-BUSY): nd_r_b_n=1, nd_io_oe=0, nd_io_out=0, fetch_req=0, fetch_row=0, column=0, id_idx=0, counter=0, mode NONE, state IDLE, synchronizers = idle levels (ce_n, we_n, re_n high).

Test Plan:
- rst, then FFh -> nd_r_b_n low for 250 (±1) cycles then high; fetch_req stays 0.
- 90h, addr 00h, 5 RE pulses -> bytes EC, D3, 51, 95, EC; nd_io_oe high only while re_n low.
- 00h, addr 04,00,12,34,00, 30h, fetch_ack 10 cycles later -> fetch_row=24'h003412, busy 250 cycles, then data_addr=4 and successive RE reads return data_in for columns 4, 5, 6.
- During that BUSY: 70h, RE -> 8'h80 (wp_n=1); after ready, RE -> 8'hE0; 00h -> DATA mode resumes at the unchanged column, no address phase.
- Column 2111 read, then RE -> data_addr=0; command ABh and a stray address byte in IDLE -> no state, mode or R/B# change.
- rst asserted mid-BUSY with fetch_req=1 -> next cycle nd_r_b_n=1, fetch_req=0, nd_io_oe=0.
